// File: rtl/qspi_mem_target.sv
// QSPI PSRAM emulator: oversamples SCK/CS/SD on clk_i and turns the 0x35/0xEB/0x38/0xF5
// command subset into byte reads and writes on a simple memory port.
module qspi_mem_target #(
    parameter int ADDR_W       = 16,
    parameter int DUMMY_CYCLES = 6
) (
    input  logic              clk_i,
    input  logic              rst_in,
    input  logic              cs_in,
    input  logic              sck_i,
    input  logic [3:0]        sd_i,
    output logic [3:0]        sd_o,
    output logic [3:0]        sd_oe_o,
    output logic              qpi_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic              mem_re_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              mem_we_o,
    output logic [7:0]        mem_wdata_o
);
    typedef enum logic [2:0] {
        ST_CMD, ST_ADDR, ST_DUMMY, ST_RD_DATA, ST_WR_DATA, ST_IGNORE
    } state_t;

    // Only the low ADDR_W address bits are kept; upper nibbles shift out and are dropped.
    localparam int SH_W = ADDR_W - 4;
    localparam logic [3:0] DUMMY_LAST = 4'((DUMMY_CYCLES > 0) ? (DUMMY_CYCLES - 1) : 0);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic              cs_meta_r, cs_sync_r;
    logic              sck_meta_r, sck_sync_r, sck_prev_r;
    logic [3:0]        sd_meta_r, sd_sync_r;
    state_t            state_r;
    logic [3:0]        cnt_r;
    logic [SH_W-1:0]   shift_r;
    logic              is_wr_r, qpi_r, rd_lo_r, wr_half_r, re_d_r;
    logic [ADDR_W-1:0] addr_r, mem_adr_r;
    logic [7:0]        byte_r, mem_wdata_r;
    logic [3:0]        lo_nib_r, wr_hi_r, sd_r, sd_oe_r;
    logic              mem_re_r, mem_we_r;

    logic              rise_s, fall_s;
    logic [7:0]        spi_byte_s, qpi_byte_s;
    logic [ADDR_W-1:0] addr_low_s;

    assign rise_s     = sck_sync_r & ~sck_prev_r;
    assign fall_s     = ~sck_sync_r & sck_prev_r;
    assign spi_byte_s = {shift_r[6:0], sd_sync_r[0]};
    assign qpi_byte_s = {shift_r[3:0], sd_sync_r};
    assign addr_low_s = {shift_r, sd_sync_r};

    assign sd_o        = sd_r;
    assign sd_oe_o     = sd_oe_r;
    assign qpi_o       = qpi_r;
    assign mem_adr_o   = mem_adr_r;
    assign mem_re_o    = mem_re_r;
    assign mem_we_o    = mem_we_r;
    assign mem_wdata_o = mem_wdata_r;

    // Two-flop synchronizers for all pins plus the SCK edge-detect history flop.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cs_meta_r  <= 1'b1;
            cs_sync_r  <= 1'b1;
            sck_meta_r <= 1'b0;
            sck_sync_r <= 1'b0;
            sck_prev_r <= 1'b0;
            sd_meta_r  <= 4'h0;
            sd_sync_r  <= 4'h0;
        end else begin
            cs_meta_r  <= cs_in;
            cs_sync_r  <= cs_meta_r;
            sck_meta_r <= sck_i;
            sck_sync_r <= sck_meta_r;
            sck_prev_r <= sck_sync_r;
            sd_meta_r  <= sd_i;
            sd_sync_r  <= sd_meta_r;
        end
    end

    // Protocol FSM with registered memory-port and pad outputs.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_r     <= ST_CMD;
            cnt_r       <= 4'd0;
            shift_r     <= '0;
            is_wr_r     <= 1'b0;
            qpi_r       <= 1'b0;
            rd_lo_r     <= 1'b0;
            wr_half_r   <= 1'b0;
            re_d_r      <= 1'b0;
            addr_r      <= '0;
            mem_adr_r   <= '0;
            byte_r      <= 8'h00;
            mem_wdata_r <= 8'h00;
            lo_nib_r    <= 4'h0;
            wr_hi_r     <= 4'h0;
            sd_r        <= 4'h0;
            sd_oe_r     <= 4'h0;
            mem_re_r    <= 1'b0;
            mem_we_r    <= 1'b0;
        end else begin
            mem_re_r <= 1'b0;
            mem_we_r <= 1'b0;
            re_d_r   <= mem_re_r;
            if (re_d_r) begin
                byte_r <= mem_rdata_i;
            end
            if (cs_sync_r) begin
                state_r   <= ST_CMD;
                cnt_r     <= 4'd0;
                sd_oe_r   <= 4'h0;
                sd_r      <= 4'h0;
                byte_r    <= 8'h00;
                rd_lo_r   <= 1'b0;
                wr_half_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_CMD: begin
                        if (rise_s && !qpi_r) begin
                            shift_r <= {shift_r[SH_W-2:0], sd_sync_r[0]};
                            if (cnt_r == 4'd7) begin
                                cnt_r   <= 4'd0;
                                state_r <= ST_IGNORE;
                                if (spi_byte_s == 8'h35) begin
                                    qpi_r <= 1'b1;
                                end
                            end else begin
                                cnt_r <= cnt_r + 4'd1;
                            end
                        end else if (rise_s) begin
                            shift_r <= {shift_r[SH_W-5:0], sd_sync_r};
                            if (cnt_r == 4'd1) begin
                                cnt_r <= 4'd0;
                                case (qpi_byte_s)
                                    8'hEB: begin is_wr_r <= 1'b0; state_r <= ST_ADDR; end
                                    8'h38: begin is_wr_r <= 1'b1; state_r <= ST_ADDR; end
                                    8'hF5: begin qpi_r <= 1'b0; state_r <= ST_IGNORE; end
                                    default: state_r <= ST_IGNORE;
                                endcase
                            end else begin
                                cnt_r <= cnt_r + 4'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (rise_s) begin
                            shift_r <= {shift_r[SH_W-5:0], sd_sync_r};
                            if (cnt_r == 4'd5) begin
                                cnt_r  <= 4'd0;
                                addr_r <= addr_low_s;
                                if (is_wr_r) begin
                                    state_r <= ST_WR_DATA;
                                end else begin
                                    // Prefetch the first byte so it is ready by the first falling edge.
                                    mem_re_r  <= 1'b1;
                                    mem_adr_r <= addr_low_s;
                                    state_r   <= (DUMMY_CYCLES == 0) ? ST_RD_DATA : ST_DUMMY;
                                end
                            end else begin
                                cnt_r <= cnt_r + 4'd1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        sd_oe_r <= 4'h0;
                        if (rise_s) begin
                            if (cnt_r == DUMMY_LAST) begin
                                cnt_r   <= 4'd0;
                                state_r <= ST_RD_DATA;
                            end else begin
                                cnt_r <= cnt_r + 4'd1;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (fall_s) begin
                            sd_oe_r <= 4'hF;
                            if (!rd_lo_r) begin
                                // Low nibble is parked so the next prefetch may overwrite byte_r.
                                sd_r      <= byte_r[7:4];
                                lo_nib_r  <= byte_r[3:0];
                                rd_lo_r   <= 1'b1;
                                addr_r    <= addr_r + ADDR_ONE;
                                mem_re_r  <= 1'b1;
                                mem_adr_r <= addr_r + ADDR_ONE;
                            end else begin
                                sd_r    <= lo_nib_r;
                                rd_lo_r <= 1'b0;
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (rise_s) begin
                            if (!wr_half_r) begin
                                wr_hi_r   <= sd_sync_r;
                                wr_half_r <= 1'b1;
                            end else begin
                                mem_we_r    <= 1'b1;
                                mem_wdata_r <= {wr_hi_r, sd_sync_r};
                                mem_adr_r   <= addr_r;
                                addr_r      <= addr_r + ADDR_ONE;
                                wr_half_r   <= 1'b0;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        sd_oe_r <= 4'h0;
                    end
                    default: begin
                        state_r <= ST_IGNORE;
                    end
                endcase
            end
        end
    end
endmodule
